// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480 VGA raster counters, delayed blank/sync and frame markers
module vga_delay #(
  parameter int W = 1,
  parameter int D = 1,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         vga_clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (D == 0) begin : g_pass
    assign q = d;
  end else begin : g_sr
    logic [W-1:0] sr [D];
    always_ff @(posedge vga_clk or negedge reset_n)
      if (!reset_n) for (int i = 0; i < D; i++) sr[i] <= INIT;
      else begin
        sr[0] <= d;
        for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
      end
    assign q = sr[D-1];
  end
endmodule

module vga_timing_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int BLANK_DELAY = 1,
  parameter int SYNC_DELAY  = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       sync,
  output logic       frame_start,
  output logic [7:0] frame_count
);
  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  logic [9:0] hc, vc;
  logic       h_end, v_end, wrap;
  logic       blank_raw, hs_raw, vs_raw;
  logic [1:0] hs_vs;
  assign h_end     = hc == H_LAST;
  assign v_end     = vc == V_LAST;
  assign wrap      = h_end && v_end;
  assign blank_raw = (hc < H_VIS) && (vc < V_VIS);
  assign hs_raw    = !((hc >= HS_BEG) && (hc < HS_END));
  assign vs_raw    = !((vc >= VS_BEG) && (vc < VS_END));
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) begin
      hc          <= '0;
      vc          <= '0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      hc          <= h_end ? '0 : hc + 10'd1;
      vc          <= h_end ? (v_end ? '0 : vc + 10'd1) : vc;
      frame_start <= wrap;
      frame_count <= frame_count + {7'd0, wrap};
    end
  vga_delay #(.W(1), .D(BLANK_DELAY), .INIT(1'b0)) u_blank (
    .vga_clk(vga_clk), .reset_n(reset_n), .d(blank_raw), .q(blank)
  );
  vga_delay #(.W(2), .D(SYNC_DELAY), .INIT(2'b11)) u_sync (
    .vga_clk(vga_clk), .reset_n(reset_n), .d({hs_raw, vs_raw}), .q(hs_vs)
  );
  assign {hs, vs} = hs_vs;
  assign DrawX    = hc;
  assign DrawY    = vc;
  assign sync     = 1'b0;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default-timing line checks plus a scoreboarded shrunk-raster instance
module tb_vga_timing_gen;
  localparam int HT = 25, VT = 8, BD = 0, SD = 3;
  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  logic [9:0] dx_d, dy_d, dx_s, dy_s;
  logic bl_d, hs_d, vs_d, sy_d, fs_d, bl_s, hs_s, vs_s, sy_s, fs_s;
  logic [7:0] fc_d, fc_s;
  int total = 0, bad = 0, cyc = 0, pulses = 0, last_fs = -1;
  logic [31:0] sbq[$];
  int mh, mv;
  logic mfs;
  logic [7:0] mfc;
  logic bh[5], hh[5], vh[5];
  always #5 vga_clk = ~vga_clk;
  vga_timing_gen dut_d (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(dx_d), .DrawY(dy_d), .blank(bl_d),
    .hs(hs_d), .vs(vs_d), .sync(sy_d), .frame_start(fs_d), .frame_count(fc_d)
  );
  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .BLANK_DELAY(BD), .SYNC_DELAY(SD)
  ) dut_s (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(dx_s), .DrawY(dy_s), .blank(bl_s),
    .hs(hs_s), .vs(vs_s), .sync(sy_s), .frame_start(fs_s), .frame_count(fc_s)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [2:0] raw(input int h, input int v);
    return {h < 16 && v < 4, !(h >= 18 && h < 22), !(v >= 5 && v < 7)};
  endfunction
  initial forever begin
    @(posedge vga_clk or negedge reset_n);
    if (!reset_n) begin
      mh = 0; mv = 0; mfs = 1'b0; mfc = 8'd0;
      for (int k = 1; k < 5; k++) begin bh[k] = 1'b0; hh[k] = 1'b1; vh[k] = 1'b1; end
      {bh[0], hh[0], vh[0]} = raw(0, 0);
    end else begin
      for (int k = 4; k > 0; k--) begin bh[k] = bh[k-1]; hh[k] = hh[k-1]; vh[k] = vh[k-1]; end
      mfs = (mh == HT-1) && (mv == VT-1);
      if (mfs) mfc = mfc + 8'd1;
      if (mh == HT-1) begin mh = 0; mv = (mv == VT-1) ? 0 : mv + 1; end
      else mh = mh + 1;
      {bh[0], hh[0], vh[0]} = raw(mh, mv);
      sbq.push_back({10'(mh), 10'(mv), bh[BD], hh[SD], vh[SD], mfs, mfc});
    end
  end
  initial forever begin
    logic [31:0] e;
    @(negedge vga_clk);
    cyc++;
    if (!reset_n) last_fs = -1;
    else if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("sb", {dx_s, dy_s, bl_s, hs_s, vs_s, fs_s, fc_s}, e);
      chk("sync_s", {31'd0, sy_s}, 0);
      if (fs_s) begin
        pulses++;
        if (last_fs >= 0) chk("fs_gap", cyc - last_fs, HT*VT);
        last_fs = cyc;
        if (pulses == 1) chk("fc_1", {24'd0, fc_s}, 1);
        if (pulses == 2) chk("fc_2", {24'd0, fc_s}, 2);
        if (pulses == 256) chk("fc_wrap", {24'd0, fc_s}, 0);
      end
    end
  end
  initial begin
    int bf, hf, hr, hx, hy, fsn;
    logic pb, ph, found;
    repeat (5) @(posedge vga_clk);
    @(negedge vga_clk);
    chk("rst_xy", {dx_d, dy_d}, 0);
    chk("rst_blank", {31'd0, bl_d}, 0);
    chk("rst_hsvs", {30'd0, hs_d, vs_d}, 3);
    chk("rst_fs", {31'd0, fs_d}, 0);
    chk("rst_fc", {24'd0, fc_d}, 0);
    chk("rst_sync", {31'd0, sy_d}, 0);
    chk("rst_s", {dx_s, dy_s, bl_s, hs_s, vs_s, fs_s, fc_s}, {20'd0, 4'b1110, 8'd0});
    reset_n = 1'b1;
    #1 chk("rel_x0", {22'd0, dx_d}, 0);
    bf = -1; hf = -1; hr = -1; pb = bl_d; ph = hs_d;
    for (int i = 1; i <= 800; i++) begin
      @(negedge vga_clk);
      if (i <= 3) chk("x_count", {22'd0, dx_d}, i);
      if (i == 1) chk("blank_on", {31'd0, bl_d}, 1);
      if (pb && !bl_d && bf < 0) bf = dx_d;
      if (ph && !hs_d && hf < 0) hf = dx_d;
      if (!ph && hs_d && hr < 0) hr = dx_d;
      pb = bl_d; ph = hs_d;
    end
    chk("blank_fall", bf, 641);
    chk("hs_fall", hf, 658);
    chk("hs_rise", hr, 754);
    chk("line_wrap", {dx_d, dy_d}, {10'd0, 10'd1});
    for (int i = 0; i < 60000 && pulses < 258; i++) @(negedge vga_clk);
    chk("frames_seen", {31'd0, pulses >= 258}, 1);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge vga_clk);
      found = (dx_s == 10'd23) && (dy_s == 10'd2);
    end
    chk("find_23_2", {31'd0, found}, 1);
    chk("hs_low_pre", {31'd0, hs_s}, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_xy_s", {dx_s, dy_s}, 0);
    chk("ar_hsvs_s", {30'd0, hs_s, vs_s}, 3);
    chk("ar_fs_fc_s", {23'd0, fs_s, fc_s}, 0);
    chk("ar_xy_d", {dx_d, dy_d}, 0);
    chk("ar_blank_d", {31'd0, bl_d}, 0);
    repeat (3) @(negedge vga_clk);
    reset_n = 1'b1;
    hx = -1; hy = -1; fsn = 0;
    for (int i = 0; i < 1000 && hx < 0; i++) begin
      @(negedge vga_clk);
      if (fs_d) fsn++;
      if (!hs_d) begin hx = dx_d; hy = dy_d; end
    end
    chk("post_hs_x", hx, 658);
    chk("post_hs_y", hy, 0);
    chk("post_no_fs", fsn, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
